// File: rtl/spi_slave_frontend.sv
// SPI slave front end: decodes 16-bit R/W+address+data frames into register-bank strobes.
// Latency: addr/reg_re one clk after the 8th sample edge, reg_we one clk after the 16th.
// Backpressure: none; the register bank must accept every strobe, and ena=0 freezes all state.
module spi_slave_frontend #(
  parameter int ADDR_W = 3
) (
  input  logic              clk,
  input  logic              rstb,
  input  logic              ena,
  input  logic [1:0]        mode,
  input  logic              spi_cs_n,
  input  logic              spi_clk,
  input  logic              spi_mosi,
  output logic              spi_miso,
  output logic [ADDR_W-1:0] reg_addr,
  output logic [7:0]        reg_wdata,
  output logic              reg_we,
  output logic              reg_re,
  input  logic [7:0]        reg_rdata,
  output logic              busy
);

  // cs_armed: chip select has been seen high, so the next low level is a genuine frame start.
  // This keeps a frame from starting when reset releases with spi_cs_n already low.
  logic        cs_armed;
  logic [1:0]  mode_q;
  logic        sclk_prev;
  logic [4:0]  bit_cnt;
  logic [14:0] rx_sh;
  logic [7:0]  tx_sh;

  logic sclk_rise;
  logic sclk_fall;
  logic sample_on_rise;
  logic sample_edge;
  logic shift_edge;

  // Modes 0 and 3 sample on the rising edge, modes 1 and 2 on the falling edge.
  assign sclk_rise      = spi_clk & ~sclk_prev;
  assign sclk_fall      = ~spi_clk & sclk_prev;
  assign sample_on_rise = ~(mode_q[1] ^ mode_q[0]);
  assign sample_edge    = sample_on_rise ? sclk_rise : sclk_fall;
  assign shift_edge     = sample_on_rise ? sclk_fall : sclk_rise;

  // Frame tracking, serial shift, command decode and strobe generation.
  always_ff @(posedge clk or negedge rstb) begin
    if (!rstb) begin
      cs_armed  <= 1'b0;
      mode_q    <= 2'b00;
      sclk_prev <= 1'b0;
      bit_cnt   <= 5'd0;
      rx_sh     <= 15'd0;
      tx_sh     <= 8'd0;
      spi_miso  <= 1'b0;
      reg_addr  <= '0;
      reg_wdata <= 8'h00;
      reg_we    <= 1'b0;
      reg_re    <= 1'b0;
      busy      <= 1'b0;
    end else if (ena) begin
      // Strobes are single-cycle by default; previous spi_clk tracks every enabled cycle,
      // which also loads it at frame start so the first cycle sees no edge.
      reg_we    <= 1'b0;
      reg_re    <= 1'b0;
      sclk_prev <= spi_clk;
      if (spi_cs_n) begin
        // Deselect wins over any edge seen in the same cycle.
        cs_armed <= 1'b1;
        busy     <= 1'b0;
        bit_cnt  <= 5'd0;
        rx_sh    <= 15'd0;
        tx_sh    <= 8'd0;
        spi_miso <= 1'b0;
      end else if (!busy) begin
        if (cs_armed) begin
          cs_armed <= 1'b0;
          busy     <= 1'b1;
          mode_q   <= mode;
        end
      end else begin
        // Read data is valid only while reg_re is high, so load it in exactly that cycle.
        if (reg_re) begin
          tx_sh <= reg_rdata;
        end else if (shift_edge) begin
          spi_miso <= tx_sh[7];
          tx_sh    <= {tx_sh[6:0], 1'b0};
        end
        if (sample_edge && (bit_cnt < 5'd16)) begin
          rx_sh   <= {rx_sh[13:0], spi_mosi};
          bit_cnt <= bit_cnt + 5'd1;
          // 8th bit completes the command byte; R/W bit currently sits at rx_sh[6].
          if (bit_cnt == 5'd7) begin
            reg_addr <= ADDR_W'({rx_sh[5:0], spi_mosi});
            reg_re   <= ~rx_sh[6];
          end
          // 16th bit completes the data byte; R/W bit has moved to rx_sh[14].
          if (bit_cnt == 5'd15) begin
            reg_we <= rx_sh[14];
            if (rx_sh[14]) begin
              reg_wdata <= {rx_sh[6:0], spi_mosi};
            end
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_spi_slave_frontend.sv
module tb_spi_slave_frontend;
  localparam int ADDR_W = 3;
  localparam int HALF   = 6;

  logic              clk = 1'b0;
  logic              rstb;
  logic              ena;
  logic [1:0]        mode;
  logic              spi_cs_n;
  logic              spi_clk;
  logic              spi_mosi;
  logic              spi_miso;
  logic [ADDR_W-1:0] reg_addr;
  logic [7:0]        reg_wdata;
  logic              reg_we;
  logic              reg_re;
  logic [7:0]        reg_rdata;
  logic              busy;
  logic [7:0]        rd_val;

  int checks   = 0;
  int failures = 0;

  int                we_total = 0;
  int                re_total = 0;
  logic [ADDR_W-1:0] we_addr;
  logic [7:0]        we_data;
  logic [ADDR_W-1:0] re_addr;

  always #5 clk = ~clk;

  // Read data is only meaningful while reg_re is high; junk otherwise.
  assign reg_rdata = reg_re ? rd_val : 8'hEE;

  spi_slave_frontend #(.ADDR_W(ADDR_W)) dut (
    .clk(clk), .rstb(rstb), .ena(ena), .mode(mode),
    .spi_cs_n(spi_cs_n), .spi_clk(spi_clk), .spi_mosi(spi_mosi), .spi_miso(spi_miso),
    .reg_addr(reg_addr), .reg_wdata(reg_wdata), .reg_we(reg_we), .reg_re(reg_re),
    .reg_rdata(reg_rdata), .busy(busy)
  );

  // Strobe monitor: counts pulses and records the address/data seen with each.
  always @(negedge clk) begin
    if (reg_we) begin
      we_total = we_total + 1;
      we_addr  = reg_addr;
      we_data  = reg_wdata;
    end
    if (reg_re) begin
      re_total = re_total + 1;
      re_addr  = reg_addr;
    end
  end

  // SPI master: drives nbits of word MSB first (zeros beyond 16), captures miso at its sample edge.
  // The mode input is flipped mid-frame to show the latched mode is used.
  task automatic spi_frame(input logic [1:0] m, input logic [15:0] word, input int nbits,
                           input bit release_cs, output logic [15:0] miso_word, output logic busy_mid);
    logic cpol, cpha, b;
    cpol = m[1];
    cpha = m[0];
    miso_word = 16'h0000;
    mode = m;
    spi_clk = cpol;
    spi_mosi = 1'b0;
    spi_cs_n = 1'b1;
    repeat (4) @(negedge clk);
    spi_cs_n = 1'b0;
    repeat (2) @(negedge clk);
    busy_mid = busy;
    mode = ~m;
    repeat (HALF - 2) @(negedge clk);
    for (int i = 0; i < nbits; i++) begin
      b = (i < 16) ? word[15-i] : 1'b0;
      spi_mosi = b;
      if (!cpha) begin
        repeat (HALF) @(negedge clk);
        if (i < 16) miso_word[15-i] = spi_miso;
        spi_clk = ~cpol;
        repeat (HALF) @(negedge clk);
        spi_clk = cpol;
      end else begin
        spi_clk = ~cpol;
        repeat (HALF) @(negedge clk);
        if (i < 16) miso_word[15-i] = spi_miso;
        spi_clk = cpol;
        repeat (HALF) @(negedge clk);
      end
    end
    repeat (HALF) @(negedge clk);
    if (release_cs) begin
      spi_cs_n = 1'b1;
      repeat (3) @(negedge clk);
    end
  endtask

  task automatic test_reset;
    rstb = 1'b0; ena = 1'b1; mode = 2'b00; spi_cs_n = 1'b1; spi_clk = 1'b0; spi_mosi = 1'b0; rd_val = 8'h00;
    repeat (3) @(negedge clk);
    checks++; if (spi_miso !== 1'b0) begin failures++; $display("FAIL reset_miso: got %b expected 0", spi_miso); end
    checks++; if (reg_we !== 1'b0) begin failures++; $display("FAIL reset_we: got %b expected 0", reg_we); end
    checks++; if (reg_re !== 1'b0) begin failures++; $display("FAIL reset_re: got %b expected 0", reg_re); end
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL reset_busy: got %b expected 0", busy); end
    checks++; if (reg_addr !== 3'd0) begin failures++; $display("FAIL reset_addr: got %h expected 0", reg_addr); end
    checks++; if (reg_wdata !== 8'h00) begin failures++; $display("FAIL reset_wdata: got %h expected 00", reg_wdata); end
    rstb = 1'b1;
    repeat (3) @(negedge clk);
  endtask

  task automatic test_write_mode0;
    logic [15:0] mw; logic bm; int we0, re0;
    we0 = we_total; re0 = re_total;
    spi_frame(2'b00, 16'h85A5, 16, 1'b1, mw, bm);
    checks++; if (bm !== 1'b1) begin failures++; $display("FAIL w0_busy_mid: got %b expected 1", bm); end
    checks++; if (we_total - we0 !== 1) begin failures++; $display("FAIL w0_we_count: got %0d expected 1", we_total - we0); end
    checks++; if (re_total - re0 !== 0) begin failures++; $display("FAIL w0_re_count: got %0d expected 0", re_total - re0); end
    checks++; if (we_addr !== 3'd5) begin failures++; $display("FAIL w0_addr: got %h expected 5", we_addr); end
    checks++; if (we_data !== 8'hA5) begin failures++; $display("FAIL w0_wdata: got %h expected a5", we_data); end
    checks++; if (mw !== 16'h0000) begin failures++; $display("FAIL w0_miso: got %h expected 0000", mw); end
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL w0_busy_after: got %b expected 0", busy); end
    checks++; if (reg_wdata !== 8'hA5) begin failures++; $display("FAIL w0_wdata_hold: got %h expected a5", reg_wdata); end
  endtask

  task automatic test_read_mode3;
    logic [15:0] mw; logic bm; int we0, re0;
    we0 = we_total; re0 = re_total; rd_val = 8'h3C;
    spi_frame(2'b11, 16'h0300, 16, 1'b1, mw, bm);
    checks++; if (re_total - re0 !== 1) begin failures++; $display("FAIL r3_re_count: got %0d expected 1", re_total - re0); end
    checks++; if (we_total - we0 !== 0) begin failures++; $display("FAIL r3_we_count: got %0d expected 0", we_total - we0); end
    checks++; if (re_addr !== 3'd3) begin failures++; $display("FAIL r3_addr: got %h expected 3", re_addr); end
    checks++; if (mw !== 16'h003C) begin failures++; $display("FAIL r3_miso: got %h expected 003c", mw); end
    checks++; if (spi_miso !== 1'b0) begin failures++; $display("FAIL r3_miso_idle: got %b expected 0", spi_miso); end
  endtask

  task automatic test_read_mode12;
    logic [15:0] mw; logic bm; int re0; logic [1:0] mm;
    rd_val = 8'hC3;
    for (int k = 1; k <= 2; k++) begin
      mm = 2'(k);
      re0 = re_total;
      spi_frame(mm, 16'h0700, 16, 1'b1, mw, bm);
      checks++; if (re_total - re0 !== 1) begin failures++; $display("FAIL r%0d_re_count: got %0d expected 1", k, re_total - re0); end
      checks++; if (re_addr !== 3'd7) begin failures++; $display("FAIL r%0d_addr: got %h expected 7", k, re_addr); end
      checks++; if (mw !== 16'h00C3) begin failures++; $display("FAIL r%0d_miso: got %h expected 00c3", k, mw); end
    end
  endtask

  task automatic test_abort;
    logic [15:0] mw; logic bm; int we0, re0;
    we0 = we_total; re0 = re_total;
    spi_frame(2'b00, 16'h8677, 12, 1'b1, mw, bm);
    checks++; if (we_total - we0 !== 0) begin failures++; $display("FAIL abort_we: got %0d expected 0", we_total - we0); end
    checks++; if (re_total - re0 !== 0) begin failures++; $display("FAIL abort_re: got %0d expected 0", re_total - re0); end
    checks++; if (reg_wdata !== 8'hA5) begin failures++; $display("FAIL abort_wdata_hold: got %h expected a5", reg_wdata); end
    we0 = we_total;
    spi_frame(2'b00, 16'h8211, 16, 1'b1, mw, bm);
    checks++; if (we_total - we0 !== 1) begin failures++; $display("FAIL after_abort_we: got %0d expected 1", we_total - we0); end
    checks++; if (we_addr !== 3'd2) begin failures++; $display("FAIL after_abort_addr: got %h expected 2", we_addr); end
    checks++; if (we_data !== 8'h11) begin failures++; $display("FAIL after_abort_wdata: got %h expected 11", we_data); end
  endtask

  task automatic test_reset_mid;
    logic [15:0] mw; logic bm; int we0, re0;
    we0 = we_total; re0 = re_total;
    spi_frame(2'b00, 16'h8499, 10, 1'b0, mw, bm);
    rstb = 1'b0;
    repeat (2) @(negedge clk);
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL rstmid_busy: got %b expected 0", busy); end
    checks++; if (reg_addr !== 3'd0) begin failures++; $display("FAIL rstmid_addr: got %h expected 0", reg_addr); end
    checks++; if (reg_wdata !== 8'h00) begin failures++; $display("FAIL rstmid_wdata: got %h expected 00", reg_wdata); end
    checks++; if (spi_miso !== 1'b0) begin failures++; $display("FAIL rstmid_miso: got %b expected 0", spi_miso); end
    rstb = 1'b1;
    repeat (10) @(negedge clk);
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL rstmid_no_restart: got %b expected 0", busy); end
    checks++; if (we_total - we0 !== 0 || re_total - re0 !== 0) begin failures++; $display("FAIL rstmid_strobes: got we=%0d re=%0d expected 0", we_total - we0, re_total - re0); end
    spi_frame(2'b00, 16'h8642, 16, 1'b1, mw, bm);
    checks++; if (we_total - we0 !== 1) begin failures++; $display("FAIL rstmid_next_we: got %0d expected 1", we_total - we0); end
    checks++; if (we_addr !== 3'd6) begin failures++; $display("FAIL rstmid_next_addr: got %h expected 6", we_addr); end
    checks++; if (we_data !== 8'h42) begin failures++; $display("FAIL rstmid_next_wdata: got %h expected 42", we_data); end
  endtask

  task automatic test_extra_clocks;
    logic [15:0] mw; logic bm; int we0, re0;
    we0 = we_total; re0 = re_total;
    spi_frame(2'b00, 16'h815A, 20, 1'b1, mw, bm);
    checks++; if (we_total - we0 !== 1) begin failures++; $display("FAIL extra_we: got %0d expected 1", we_total - we0); end
    checks++; if (re_total - re0 !== 0) begin failures++; $display("FAIL extra_re: got %0d expected 0", re_total - re0); end
    checks++; if (we_data !== 8'h5A) begin failures++; $display("FAIL extra_wdata: got %h expected 5a", we_data); end
    checks++; if (we_addr !== 3'd1) begin failures++; $display("FAIL extra_addr: got %h expected 1", we_addr); end
  endtask

  initial begin
    test_reset();
    test_write_mode0();
    test_read_mode3();
    test_read_mode12();
    test_abort();
    test_reset_mid();
    test_extra_clocks();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
